// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: NUM_CH producer lanes, force controls and one registered output lane.
interface stream_mux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2
);
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic                         force_en;
  logic [CH_W-1:0]              force_sel;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]              out_ch;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux.sv
// NUM_CH-way valid/ready mux into one output register: 1-cycle latency, 1 word/cycle, in_ready low while the output stalls.
// STREAM_MUX_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest eligible index wins.
module stream_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2
) (
  input logic         clk,
  input logic         rst_n,
  stream_mux_if.slave bus
);

  logic [NUM_CH-1:0]     eligible;
  logic                  load;
  logic                  any;
  logic [CH_W-1:0]       gnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CH_W-1:0]       ch_q;
  logic                  valid_q;
`ifdef STREAM_MUX_ROUND_ROBIN_EN
  logic [CH_W-1:0]       ptr;
`endif

  // The slot can take a new word when it is empty or being drained this cycle.
  assign load = ~valid_q | bus.out_ready;
  assign any  = |eligible;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = bus.in_valid[i] & (~bus.force_en | (bus.force_sel == CH_W'(i)));
    end
  end

`ifdef STREAM_MUX_ROUND_ROBIN_EN
  // Scan backwards so the last hit is the first eligible channel after ptr.
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (eligible[idx]) gnt = CH_W'(idx);
    end
  end
`else
  always_comb begin
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) gnt = CH_W'(i);
    end
  end
`endif

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.in_ready[i] = rst_n & load & any & (gnt == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
`ifdef STREAM_MUX_ROUND_ROBIN_EN
      ptr     <= CH_W'(NUM_CH - 1);
`endif
    end else if (load) begin
      valid_q <= any;
      if (any) begin
        data_q <= bus.in_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        ch_q   <= gnt;
`ifdef STREAM_MUX_ROUND_ROBIN_EN
        ptr    <= gnt;
`endif
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Drives instances A (32b x4) and B (5b x3) in lockstep; a per-instance reference model feeds a scoreboard checked by monitors.
module tb_stream_mux;

  typedef struct {
    logic [31:0] data;
    int          ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  drv_valid;
  logic [31:0] drv_data [4];
  logic        fen;
  logic [1:0]  fsel;
  logic        out_rdy;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa [$];
  exp_t qb [$];
  bit   full  [2];
  int   rr_ptr [2];
  bit   fresh [2];

  always #5 clk = ~clk;

  stream_mux_if #(.DATA_WIDTH(32), .NUM_CH(4), .CH_W(2)) ia ();
  stream_mux_if #(.DATA_WIDTH(5),  .NUM_CH(3), .CH_W(2)) ib ();

  assign ia.in_valid  = drv_valid;
  assign ia.in_data   = {drv_data[3], drv_data[2], drv_data[1], drv_data[0]};
  assign ia.force_en  = fen;
  assign ia.force_sel = fsel;
  assign ia.out_ready = out_rdy;
  assign ib.in_valid  = drv_valid[2:0];
  assign ib.in_data   = {drv_data[2][4:0], drv_data[1][4:0], drv_data[0][4:0]};
  assign ib.force_en  = fen;
  assign ib.force_sel = fsel;
  assign ib.out_ready = out_rdy;

  stream_mux #(.DATA_WIDTH(32), .NUM_CH(4), .CH_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  stream_mux #(.DATA_WIDTH(5),  .NUM_CH(3), .CH_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: winner is the first requesting channel in arbitration order among those allowed by force.
  task automatic model(input int inst);
    int          n;
    logic [3:0]  rdy_act;
    logic [3:0]  rdy_exp;
    bit          load;
    bit          found;
    int          c;
    int          g;
    exp_t        e;
    string       tag;
    n       = (inst == 0) ? 4 : 3;
    tag     = (inst == 0) ? "A" : "B";
    rdy_act = (inst == 0) ? ia.in_ready : {1'b0, ib.in_ready};
    rdy_exp = 4'b0000;
    g       = 0;
    if (!rst_n) begin
      if (inst == 0) qa.delete(); else qb.delete();
      full[inst]   = 0;
      rr_ptr[inst] = n - 1;
      fresh[inst]  = 1;
    end else begin
      load  = !full[inst] || out_rdy;
      found = 0;
      if (load) begin
        for (int k = 1; k <= n; k++) begin
`ifdef STREAM_MUX_ROUND_ROBIN_EN
          c = (rr_ptr[inst] + k) % n;
`else
          c = k - 1;
`endif
          if (!found && drv_valid[c] && (!fen || int'(fsel) == c)) begin
            found = 1;
            g     = c;
          end
        end
      end
      if (found) begin
        rdy_exp[g]   = 1'b1;
        e.data       = (inst == 0) ? drv_data[g] : (drv_data[g] & 32'h1F);
        e.ch         = g;
        if (inst == 0) qa.push_back(e); else qb.push_back(e);
        full[inst]   = 1;
        rr_ptr[inst] = g;
        fresh[inst]  = 0;
      end else if (load) begin
        full[inst] = 0;
      end
    end
    check({tag, ".in_ready"}, 32'(rdy_act), 32'(rdy_exp));
  endtask

  task automatic mon(input int inst, input logic v, input logic [31:0] d, input logic [1:0] ch, input logic r);
    exp_t  e;
    int    sz;
    string tag;
    tag = (inst == 0) ? "A" : "B";
    sz  = (inst == 0) ? qa.size() : qb.size();
    if (sz == 0) begin
      check({tag, ".out_valid_idle"}, 32'(v), 32'd0);
      if (fresh[inst]) begin
        check({tag, ".out_data_reset"}, d, 32'd0);
        check({tag, ".out_ch_reset"}, 32'(ch), 32'd0);
      end
    end else begin
      e = (inst == 0) ? qa[0] : qb[0];
      check({tag, ".out_valid"}, 32'(v), 32'd1);
      check({tag, ".out_data"}, d, e.data);
      check({tag, ".out_ch"}, 32'(ch), 32'(e.ch));
      if (r) begin
        if (inst == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end
    end
  endtask

  always @(negedge clk) if (rst_n === 1'b1) mon(0, ia.out_valid, ia.out_data, ia.out_ch, out_rdy);
  always @(negedge clk) if (rst_n === 1'b1) mon(1, ib.out_valid, 32'(ib.out_data), ib.out_ch, out_rdy);

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      model(0);
      model(1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    drv_data[0] = d0;
    drv_data[1] = d1;
    drv_data[2] = d2;
    drv_data[3] = d3;
  endtask

  initial begin
    rst_n     = 1'b0;
    drv_valid = 4'b1111;
    fen       = 1'b0;
    fsel      = 2'd0;
    out_rdy   = 1'b1;
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // reset with every producer requesting
    step(2);
    rst_n = 1'b1;

    // continuous arbitration
    step(5);
    drv_valid = 4'b0000;
    step(2);

    // backpressure: accept, stall five cycles, release
    drv_valid = 4'b1111;
    step(1);
    out_rdy = 1'b0;
    step(5);
    out_rdy = 1'b1;
    step(2);
    drv_valid = 4'b0000;
    step(2);

    // force to an existing channel, then to one that B lacks
    drv_valid = 4'b1111;
    fen       = 1'b1;
    fsel      = 2'd2;
    step(3);
    fsel = 2'd3;
    step(3);
    fen       = 1'b0;
    drv_valid = 4'b0000;
    step(2);

    // narrow data: two producers in turn, channel 2 idle
    set_data(32'h15, 32'h0A, 32'h1F, 32'h0);
    drv_valid = 4'b0011;
    step(1);
    drv_valid = 4'b0010;
    step(1);
    drv_valid = 4'b0000;
    step(2);

    // reset while stalled
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    drv_valid = 4'b1111;
    step(1);
    out_rdy = 1'b0;
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    step(3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(99) != 0);
      drv_valid = 4'($urandom);
      fen       = ($urandom_range(9) == 0);
      fsel      = 2'($urandom);
      out_rdy   = ($urandom_range(9) < 7);
      set_data($urandom, $urandom, $urandom, $urandom);
      step(1);
    end

    rst_n     = 1'b1;
    drv_valid = 4'b0000;
    fen       = 1'b0;
    out_rdy   = 1'b1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
